seg_display_ctrl: RTL
=====================

SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 Parameter: REFRESH_DIV, default 50000, clocks per digit slot (≥2).
REQ-002 Parameter: BLINK_DIV, default 25000000, clocks per blink half-period for the error display (≥2).
REQ-003 Port: clk  input  1  single system clock, all state on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: load  input  1  single-cycle strobe, captures result and flags.
REQ-006 Port: result  input  5  signed-magnitude remainder: bit4 = sign, bits3:0 = magnitude, 0..15.
REQ-007 Port: divbyzero  input  1  error flag from the remainder stage.
REQ-008 Port: zero  input  1  zero-result flag from the remainder stage.
REQ-009 Port: seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-010 Port: an  output  4  digit enables, active-low, one-hot-low, registered. an[3] is the leftmost digit.

Function
REQ-011 On a clk edge with load=1, capture result, divbyzero and zero into internal registers. The new value appears from the next digit slot driven.
REQ-012 While load=0, the captured value holds indefinitely. Input changes without load are ignored.
REQ-013 A refresh counter counts 0..REFRESH_DIV-1 and wraps. At terminal count the digit index advances 0→1→2→3→0.
REQ-014 Exactly one an bit is low at any time outside reset. an[k] is low when digit index = k.
REQ-015 Normal mode (captured divbyzero=0), digit contents:
- digit0: ones of magnitude.
- digit1: tens of magnitude, blank if tens=0.
- digit2: blank.
- digit3: "-" if sign=1 and magnitude≠0, else blank.
REQ-016 If captured zero=1 or magnitude=0, the display shows "0" on digit0 with all other digits blank, regardless of sign (no negative zero).
REQ-017 Error mode (captured divbyzero=1) shows "Err" on digits 2,1,0 and blanks digit3. Sign, magnitude and zero are ignored.
REQ-018 In error mode a blink counter counts 0..BLINK_DIV-1 and toggles a phase bit at terminal count. While phase is off, seg is all-ones (blank) but an continues scanning.
REQ-019 A load clears the blink counter and sets phase to on, so a new error is visible immediately.
REQ-020 In normal mode the blink counter is held at 0 with phase on.
REQ-021 Segment codes (active-low):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- "-"=0111111, "E"=0000110, "r"=0101111, blank=1111111
REQ-022 seg and an are updated in the same clock edge, so no digit shows another digit's segments (no ghosting).
REQ-023 If load coincides with a refresh terminal count, both take effect on that edge. The next slot shows the new value.

Reset
REQ-024 While rst_n=0: an=1111, seg=1111111, refresh counter=0, digit index=0, blink counter=0, phase=on, captured result=00000, divbyzero=0, zero=1.
REQ-025 On the first edge after rst_n rises, an=1110 and seg shows "0" (1000000).
REQ-026 Reset asserted mid-scan or mid-blink forces REQ-024 values immediately, without waiting for a clock.

Structure
REQ-027 A shared package holds the segment code constants and the digit-code type: 4-bit codes 0-9, DASH, E, R, BLANK.
REQ-028 One combinational sub-module, seg7_encode, maps a digit code to seg. It is instantiated once, ahead of the seg register.
REQ-029 Binary-to-tens/ones conversion of the 0..15 magnitude is a compare-with-10 and subtract, with no divider.

Verification (REFRESH_DIV=4, BLINK_DIV=8)
REQ-030 Reset release, no load → an cycles 1110,1101,1011,0111 every 4 clocks. seg = 1000000 on digit0 and blank on the others.
REQ-031 load with result=10011 (−3), flags 0 → digit0 = 0110000, digit3 = 0111111, digits 1 and 2 blank.
REQ-032 load with result=01101 (+13) → digit0 = 0110000 ("3"), digit1 = 1111001 ("1"), digit3 blank.
REQ-033 load with result=10000, zero=1 → only digit0 = "0", digit3 blank (negative zero suppressed).
REQ-034 load with divbyzero=1 → digits 2,1,0 show E,r,r for 8 clocks, then seg is blank for 8 clocks, repeating. A reload mid-off-phase restores visibility on the next edge.
REQ-035 Assert rst_n=0 mid-slot → an=1111 and seg=1111111 asynchronously. Captured value returns to "0" after release.

Source files
------------

// File: rtl/seg_display_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// seg_display_ctrl_pkg
// Shared definitions for the 4-digit seven-segment display controller:
//   - digit_code_t : 4-bit symbolic code for one display position
//   - SEG_*        : active-low segment patterns, bit order {g,f,e,d,c,b,a}
//   - bcd_digit()  : turns a 0..9 value into its digit code
// ---------------------------------------------------------------------------
package seg_display_ctrl_pkg;

  typedef enum logic [3:0] {
    DIG_0     = 4'd0,
    DIG_1     = 4'd1,
    DIG_2     = 4'd2,
    DIG_3     = 4'd3,
    DIG_4     = 4'd4,
    DIG_5     = 4'd5,
    DIG_6     = 4'd6,
    DIG_7     = 4'd7,
    DIG_8     = 4'd8,
    DIG_9     = 4'd9,
    DIG_DASH  = 4'd10,
    DIG_E     = 4'd11,
    DIG_R     = 4'd12,
    DIG_BLANK = 4'd13
  } digit_code_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Numeric digit codes share their value with the digit itself, so a plain
  // cast is enough; callers only pass values 0..9.
  function automatic digit_code_t bcd_digit(input logic [3:0] value);
    return digit_code_t'(value);
  endfunction

endpackage

// File: rtl/seg_display_ctrl_seg7_encode.sv
// ---------------------------------------------------------------------------
// seg7_encode
// Purely combinational digit-code to segment-pattern lookup.
//   code : digit code to display
//   seg  : active-low segments {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module seg7_encode
  import seg_display_ctrl_pkg::*;
(
  input  digit_code_t code,
  output logic [6:0]  seg
);

  // Anything outside the defined code set shows as blank rather than garbage.
  always_comb begin
    seg = SEG_BLANK;
    case (code)
      DIG_0:    seg = SEG_0;
      DIG_1:    seg = SEG_1;
      DIG_2:    seg = SEG_2;
      DIG_3:    seg = SEG_3;
      DIG_4:    seg = SEG_4;
      DIG_5:    seg = SEG_5;
      DIG_6:    seg = SEG_6;
      DIG_7:    seg = SEG_7;
      DIG_8:    seg = SEG_8;
      DIG_9:    seg = SEG_9;
      DIG_DASH: seg = SEG_DASH;
      DIG_E:    seg = SEG_E;
      DIG_R:    seg = SEG_R;
      default:  seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// ---------------------------------------------------------------------------
// seg_display_ctrl
// Multiplexed 4-digit display of a signed-magnitude remainder, with a
// blinking "Err" message when the remainder stage flags divide-by-zero.
//   clk, rst_n : system clock, asynchronous active-low reset
//   load       : one-cycle strobe capturing result/divbyzero/zero
//   result     : {sign, magnitude[3:0]}
//   divbyzero  : error flag, shows blinking "Err"
//   zero       : zero-result flag, forces a plain "0"
//   seg        : active-low segments {g,f,e,d,c,b,a}, registered
//   an         : active-low digit enables, an[3] leftmost, registered
// ---------------------------------------------------------------------------
module seg_display_ctrl
  import seg_display_ctrl_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 25000000
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [4:0] result,
  input  logic       divbyzero,
  input  logic       zero,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

  logic [RW-1:0] refresh_cnt;
  logic [1:0]    digit_idx;
  logic [BW-1:0] blink_cnt;
  logic          phase_on;
  logic [4:0]    cap_result;
  logic          cap_dbz;
  logic          cap_zero;

  logic          refresh_tc;
  logic          blink_tc;
  logic [3:0]    mag;
  logic          has_tens;
  logic [3:0]    ones;
  digit_code_t   cur_code;
  logic [6:0]    enc_seg;

  assign refresh_tc = (refresh_cnt == REFRESH_LAST);
  assign blink_tc   = (blink_cnt == BLINK_LAST);

  // Magnitude is at most 15, so the tens digit is 0 or 1 and a single
  // compare-and-subtract replaces any division.
  assign mag      = cap_result[3:0];
  assign has_tens = (mag >= 4'd10);
  assign ones     = has_tens ? (mag - 4'd10) : mag;

  // Capture register; reset value displays as a plain "0".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_result <= 5'b00000;
      cap_dbz    <= 1'b0;
      cap_zero   <= 1'b1;
    end else if (load) begin
      cap_result <= result;
      cap_dbz    <= divbyzero;
      cap_zero   <= zero;
    end
  end

  // Refresh divider and digit scan index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      digit_idx   <= 2'd0;
    end else if (refresh_tc) begin
      refresh_cnt <= '0;
      digit_idx   <= digit_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

  // Blink divider: only runs in error mode; any load restarts it with the
  // phase on so a freshly loaded error is visible straight away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (load || !cap_dbz) begin
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (blink_tc) begin
      blink_cnt <= '0;
      phase_on  <= ~phase_on;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // Select what the currently scanned position should show. Zero is always
  // an unsigned "0", and the blink off-phase blanks via the code itself so a
  // single encoder serves every case.
  always_comb begin
    cur_code = DIG_BLANK;
    if (cap_dbz) begin
      if (phase_on) begin
        case (digit_idx)
          2'd0, 2'd1: cur_code = DIG_R;
          2'd2:       cur_code = DIG_E;
          default:    cur_code = DIG_BLANK;
        endcase
      end
    end else if (cap_zero || (mag == 4'd0)) begin
      if (digit_idx == 2'd0) cur_code = DIG_0;
    end else begin
      case (digit_idx)
        2'd0:    cur_code = bcd_digit(ones);
        2'd1:    cur_code = has_tens ? DIG_1 : DIG_BLANK;
        2'd2:    cur_code = DIG_BLANK;
        default: cur_code = cap_result[4] ? DIG_DASH : DIG_BLANK;
      endcase
    end
  end

  seg7_encode u_encode (
    .code (cur_code),
    .seg  (enc_seg)
  );

  // seg and an load together from the same digit index, so a digit enable
  // is never paired with another position's segments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_BLANK;
      an  <= 4'b1111;
    end else begin
      seg <= enc_seg;
      an  <= ~(4'b0001 << digit_idx);
    end
  end

endmodule
